// File: rtl/rob_commit_if.sv
// Bundle between dispatch, execute writeback, issue lookup and retire on one side
// and the reorder buffer on the other.
interface rob_commit_if #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
);
  logic             flush;
  logic             alloc_req;
  logic [4:0]       alloc_dest_reg;
  logic             alloc_dest_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [31:0]      wb_result_hi;
  logic [31:0]      wb_result_lo;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_idx;
  logic [31:0]      commit_result_hi;
  logic [IDX_W:0]   count;
  logic             empty;

  modport master (
    output flush, alloc_req, alloc_dest_reg, alloc_dest_valid,
           wb_valid, wb_idx, wb_result_hi, wb_result_lo, rd_idx,
    input  alloc_ready, alloc_idx, rd_ready, rd_data,
           rf_we, rf_waddr, rf_wdata, commit_valid, commit_idx,
           commit_result_hi, count, empty
  );

  modport slave (
    input  flush, alloc_req, alloc_dest_reg, alloc_dest_valid,
           wb_valid, wb_idx, wb_result_hi, wb_result_lo, rd_idx,
    output alloc_ready, alloc_idx, rd_ready, rd_data,
           rf_we, rf_waddr, rf_wdata, commit_valid, commit_idx,
           commit_result_hi, count, empty
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, out-of-order writeback by index, in-order
// single-entry retire to the register file, plus a combinational operand lookup.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  rob_commit_if.slave  rob
);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] done_reg;
  logic [DEPTH-1:0] dest_en_reg;
  logic [4:0]       dest_addr_reg [DEPTH];
  logic [31:0]      res_hi_reg    [DEPTH];
  logic [31:0]      res_lo_reg    [DEPTH];

  logic [IDX_W-1:0] head_reg;
  logic [IDX_W-1:0] tail_reg;
  logic [IDX_W:0]   count_reg;

  logic             commit_valid_reg;
  logic [IDX_W-1:0] commit_idx_reg;
  logic [31:0]      commit_hi_reg;
  logic             rf_we_reg;
  logic [4:0]       rf_waddr_reg;
  logic [31:0]      rf_wdata_reg;

  logic alloc_ready;
  logic alloc_fire;
  logic commit_fire;
  logic wb_hit;
  logic bypass;

  assign alloc_ready = (count_reg < FULL_COUNT);
  // Flush wins over every same-cycle event.
  assign alloc_fire  = rob.alloc_req && alloc_ready && !rob.flush;
  assign commit_fire = valid_reg[head_reg] && done_reg[head_reg] && !rob.flush;
  assign wb_hit      = rob.wb_valid && valid_reg[rob.wb_idx] && !rob.flush;

  // The tail slot is never valid while count < DEPTH, so allocate and
  // writeback cannot target the same entry in one cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg[gi]     <= 1'b0;
        done_reg[gi]      <= 1'b0;
        dest_en_reg[gi]   <= 1'b0;
        dest_addr_reg[gi] <= '0;
        res_hi_reg[gi]    <= '0;
        res_lo_reg[gi]    <= '0;
      end else if (rob.flush) begin
        valid_reg[gi] <= 1'b0;
        done_reg[gi]  <= 1'b0;
      end else begin
        if (alloc_fire && (tail_reg == IDX_W'(gi))) begin
          valid_reg[gi]     <= 1'b1;
          done_reg[gi]      <= 1'b0;
          dest_en_reg[gi]   <= rob.alloc_dest_valid;
          dest_addr_reg[gi] <= rob.alloc_dest_reg;
        end else if (commit_fire && (head_reg == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
        if (wb_hit && (rob.wb_idx == IDX_W'(gi))) begin
          done_reg[gi]   <= 1'b1;
          res_hi_reg[gi] <= rob.wb_result_hi;
          res_lo_reg[gi] <= rob.wb_result_lo;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rob.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire)  tail_reg <= tail_reg + IDX_W'(1);
      if (commit_fire) head_reg <= head_reg + IDX_W'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + (IDX_W+1)'(1);
        2'b01:   count_reg <= count_reg - (IDX_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid_reg <= 1'b0;
      commit_idx_reg   <= '0;
      commit_hi_reg    <= '0;
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
    end else if (commit_fire) begin
      commit_valid_reg <= 1'b1;
      commit_idx_reg   <= head_reg;
      commit_hi_reg    <= res_hi_reg[head_reg];
      rf_we_reg        <= dest_en_reg[head_reg];
      rf_waddr_reg     <= dest_addr_reg[head_reg];
      rf_wdata_reg     <= res_lo_reg[head_reg];
    end else begin
      commit_valid_reg <= 1'b0;
      commit_idx_reg   <= '0;
      commit_hi_reg    <= '0;
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
    end
  end

  // Same-cycle writeback to the looked-up entry is forwarded.
  assign bypass = rob.wb_valid && (rob.wb_idx == rob.rd_idx) && valid_reg[rob.rd_idx];

  assign rob.rd_ready         = bypass || (valid_reg[rob.rd_idx] && done_reg[rob.rd_idx]);
  assign rob.rd_data          = bypass ? rob.wb_result_lo : res_lo_reg[rob.rd_idx];
  assign rob.alloc_ready      = alloc_ready;
  assign rob.alloc_idx        = tail_reg;
  assign rob.count            = count_reg;
  assign rob.empty            = (count_reg == '0);
  assign rob.commit_valid     = commit_valid_reg;
  assign rob.commit_idx       = commit_idx_reg;
  assign rob.commit_result_hi = commit_hi_reg;
  assign rob.rf_we            = rf_we_reg;
  assign rob.rf_waddr         = rf_waddr_reg;
  assign rob.rf_wdata         = rf_wdata_reg;
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: allocations queue expected retirements,
// writebacks fill in results, and a commit monitor pops and compares.
module tb_rob_commit;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rob_commit_if #(.DEPTH(16), .IDX_W(4)) rob ();

  rob_commit #(.DEPTH(16), .IDX_W(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .rob    (rob)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [4:0]  dest;
    logic        dv;
    logic [31:0] hi;
    logic [31:0] lo;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  int         n_cmp  = 0;
  int         n_err  = 0;
  logic [3:0] m_tail = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rob.flush = 1'b0; rob.alloc_req = 1'b0; rob.alloc_dest_reg = '0; rob.alloc_dest_valid = 1'b0;
    rob.wb_valid = 1'b0; rob.wb_idx = '0; rob.wb_result_hi = '0; rob.wb_result_lo = '0;
    rob.rd_idx = '0;
  endtask

  task automatic sb_wb(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo);
    foreach (sb_q[i]) begin
      if (sb_q[i].idx == idx) begin
        sb_q[i].hi = hi;
        sb_q[i].lo = lo;
      end
    end
  endtask

  task automatic do_alloc(input logic [4:0] dest, input logic dv, input bit ok);
    rob.alloc_req = 1'b1; rob.alloc_dest_reg = dest; rob.alloc_dest_valid = dv;
    #1;
    check("alloc_ready", rob.alloc_ready, ok);
    check("alloc_idx", rob.alloc_idx, m_tail);
    $display("alloc idx=%0d dest=%0d dv=%0d expect_ok=%0d", rob.alloc_idx, dest, dv, ok);
    if (ok) begin
      sb_q.push_back('{m_tail, dest, dv, 32'h0, 32'h0});
      m_tail++;
    end
    step();
    rob.alloc_req = 1'b0;
  endtask

  task automatic do_wb(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo);
    rob.wb_valid = 1'b1; rob.wb_idx = idx; rob.wb_result_hi = hi; rob.wb_result_lo = lo;
    sb_wb(idx, hi, lo);
    $display("wb idx=%0d hi=%h lo=%h", idx, hi, lo);
    step();
    rob.wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (!rob.empty && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_empty", rob.empty, 1'b1);
    step();
    step();
    check("sb_drained", sb_q.size(), 0);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (rob.commit_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_commit", rob.commit_valid, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("commit idx=%0d we=%0d waddr=%0d wdata=%h hi=%h",
                   rob.commit_idx, rob.rf_we, rob.rf_waddr, rob.rf_wdata, rob.commit_result_hi);
          check("commit_idx", rob.commit_idx, mon_e.idx);
          check("commit_rf_we", rob.rf_we, mon_e.dv);
          check("commit_waddr", rob.rf_waddr, mon_e.dest);
          check("commit_wdata", rob.rf_wdata, mon_e.lo);
          check("commit_hi", rob.commit_result_hi, mon_e.hi);
        end
      end else begin
        check("idle_rf_we", rob.rf_we, 1'b0);
      end
    end
  end

  initial begin
    idle();
    // Reset state
    step(); step();
    check("rst_alloc_ready", rob.alloc_ready, 1'b1);
    check("rst_empty", rob.empty, 1'b1);
    check("rst_count", rob.count, 0);
    check("rst_rf_we", rob.rf_we, 1'b0);
    check("rst_commit_valid", rob.commit_valid, 1'b0);
    check("rst_alloc_idx", rob.alloc_idx, 0);
    check("rst_rd_ready", rob.rd_ready, 1'b0);
    reset_n = 1'b1;
    step();

    // Three entries, reverse-order writeback, in-order retire
    do_alloc(5'd1, 1'b1, 1'b1);
    do_alloc(5'd2, 1'b1, 1'b1);
    do_alloc(5'd3, 1'b1, 1'b1);
    check("b_count", rob.count, 3);
    check("b_empty", rob.empty, 1'b0);
    do_wb(4'd2, 32'h3, 32'h30);
    do_wb(4'd1, 32'h2, 32'h20);
    do_wb(4'd0, 32'h1, 32'h10);
    check("b_we_edgeN", rob.rf_we, 1'b0);
    step();
    check("b_we_1", rob.rf_we, 1'b1);
    check("b_waddr_1", rob.rf_waddr, 5'd1);
    check("b_wdata_1", rob.rf_wdata, 32'h10);
    step();
    check("b_waddr_2", rob.rf_waddr, 5'd2);
    check("b_wdata_2", rob.rf_wdata, 32'h20);
    step();
    check("b_waddr_3", rob.rf_waddr, 5'd3);
    check("b_wdata_3", rob.rf_wdata, 32'h30);
    step();
    check("b_we_after", rob.rf_we, 1'b0);
    check("b_empty_after", rob.empty, 1'b1);

    // Reset so the fill test starts with both pointers at 0
    reset_n = 1'b0;
    step();
    sb_q.delete();
    m_tail = '0;
    reset_n = 1'b1;
    step();

    // Fill to 16, reject the 17th, then retire all 16 back-to-back
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 4), 1'b1, 1'b1);
    check("d_count_full", rob.count, 16);
    check("d_empty_full", rob.empty, 1'b0);
    do_alloc(5'd31, 1'b1, 1'b0);
    check("d_count_17th", rob.count, 16);
    for (int i = 15; i >= 0; i--) do_wb(4'(i), 32'hA000 + 32'(i), 32'h100 + 32'(i));
    wait_drain(40);
    check("d_tail_wrap", rob.alloc_idx, 0);
    check("d_count_end", rob.count, 0);

    // Flush with 5 in flight, commit-ready head, same-cycle alloc and writeback
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 1'b1, 1'b1);
    do_wb(4'd0, 32'h55, 32'h55);
    rob.flush = 1'b1;
    rob.alloc_req = 1'b1; rob.alloc_dest_reg = 5'd9; rob.alloc_dest_valid = 1'b1;
    rob.wb_valid = 1'b1; rob.wb_idx = 4'd1; rob.wb_result_lo = 32'h77;
    $display("flush with count=%0d", rob.count);
    step();
    idle();
    sb_q.delete();
    m_tail = '0;
    check("e_count", rob.count, 0);
    check("e_rf_we", rob.rf_we, 1'b0);
    check("e_commit_valid", rob.commit_valid, 1'b0);
    check("e_alloc_idx", rob.alloc_idx, 0);
    check("e_empty", rob.empty, 1'b1);

    // Writeback to a flushed index is ignored; lookup and bypass
    do_wb(4'd2, 32'h0, 32'hBAD);
    check("f_count_after_stale_wb", rob.count, 0);
    do_alloc(5'd20, 1'b0, 1'b1);
    for (int i = 1; i < 7; i++) do_alloc(5'(20 + i), 1'b1, 1'b1);
    rob.rd_idx = 4'd2;
    #1;
    check("f_rd_ready_stale", rob.rd_ready, 1'b0);
    rob.wb_valid = 1'b1; rob.wb_idx = 4'd5; rob.wb_result_hi = 32'hBEEF; rob.wb_result_lo = 32'hDEAD;
    rob.rd_idx = 4'd5;
    sb_wb(4'd5, 32'hBEEF, 32'hDEAD);
    #1;
    check("f_bypass_ready", rob.rd_ready, 1'b1);
    check("f_bypass_data", rob.rd_data, 32'hDEAD);
    rob.rd_idx = 4'd6;
    #1;
    check("f_rd6_ready", rob.rd_ready, 1'b0);
    step();
    rob.wb_valid = 1'b0;
    rob.rd_idx = 4'd5;
    #1;
    check("f_rd5_stored_ready", rob.rd_ready, 1'b1);
    check("f_rd5_stored_data", rob.rd_data, 32'hDEAD);

    // Retire including the no-destination entry at index 0
    for (int i = 0; i < 7; i++) begin
      if (i != 5) do_wb(4'(i), 32'h6000 + 32'(i), 32'h600 + 32'(i));
    end
    wait_drain(40);

    // Asynchronous reset while a commit is on the outputs
    do_alloc(5'd10, 1'b1, 1'b1);
    do_alloc(5'd11, 1'b1, 1'b1);
    do_wb(4'd7, 32'h1, 32'h777);
    step();
    check("h_rf_we_before", rob.rf_we, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("h_rf_we", rob.rf_we, 1'b0);
    check("h_commit_valid", rob.commit_valid, 1'b0);
    check("h_rf_wdata", rob.rf_wdata, 0);
    check("h_commit_hi", rob.commit_result_hi, 0);
    check("h_count", rob.count, 0);
    check("h_empty", rob.empty, 1'b1);
    check("h_alloc_ready", rob.alloc_ready, 1'b1);
    check("h_alloc_idx", rob.alloc_idx, 0);
    rob.rd_idx = 4'd8;
    #1;
    check("h_rd_ready", rob.rd_ready, 1'b0);
    sb_q.delete();
    step();
    reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

16-entry reorder buffer, consumer end of the `rob_entry_t` / `fwd_info_t` path. Dispatch allocates one entry per cycle in program order. Execute units write results back out of order by ROB index. Entries retire in order to the register file, one per cycle. It also gives issue a single combinational operand-lookup port, addressed by the 4-bit ROB index carried in `fwd_info_t`.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two.
- `IDX_W`, 4, index width; equals log2(`DEPTH`).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all in-flight entries (branch mispredict).
- `alloc_req` in 1: dispatch requests an entry this cycle.
- `alloc_dest_reg` in 5: architectural destination of the new entry.
- `alloc_dest_valid` in 1: the new entry writes a register.
- `alloc_ready` out 1: entry available, `count < DEPTH`.
- `alloc_idx` out `IDX_W`: index granted when `alloc_req && alloc_ready`; equals the tail pointer.
- `wb_valid` in 1: execute writeback strobe.
- `wb_idx` in `IDX_W`: entry being completed.
- `wb_result_hi` in 32: writeback hi result.
- `wb_result_lo` in 32: writeback lo result.
- `rd_idx` in `IDX_W`: operand lookup index.
- `rd_ready` out 1: looked-up entry holds a result.
- `rd_data` out 32: `result_lo` of the looked-up entry.
- `rf_we` out 1: register-file write enable, registered.
- `rf_waddr` out 5: register-file write address, registered.
- `rf_wdata` out 32: register-file write data (`result_lo`), registered.
- `commit_valid` out 1: an entry retired, registered; asserted even when the entry has no destination.
- `commit_idx` out `IDX_W`: index of the retired entry.
- `commit_result_hi` out 32: hi half of the retired entry, for HI/LO update.
- `count` out `IDX_W+1`: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Per-entry state: `valid`, `done`, `dest_reg`, `dest_reg_valid`, `result_hi`, `result_lo`.
- Pointers: `head` and `tail`, each `IDX_W` bits and wrapping modulo `DEPTH`. `count` is held separately, so full and empty are unambiguous when `head == tail`.
- **Allocate.** When `alloc_req && alloc_ready`:
  - entry[`tail`] gets `valid=1`, `done=0`, and the dest fields;
  - `tail` increments.
- **Allocate when full.** A request while `count == DEPTH` is ignored, even if a commit happens the same cycle.
- **Writeback.** When `wb_valid` and entry[`wb_idx`].`valid`: set `done=1` and store hi and lo.
  - A writeback to an invalid entry is ignored.
  - A second writeback to a done entry overwrites the result.
- **Commit.** When entry[`head`] is `valid && done`:
  - next cycle `commit_valid=1`, `commit_idx=head`, `commit_result_hi=result_hi`;
  - `rf_we = dest_reg_valid`, `rf_waddr = dest_reg`, `rf_wdata = result_lo`;
  - entry[`head`].`valid` clears and `head` increments.
  - Otherwise all commit outputs are 0 next cycle.
  - At most one commit per cycle.
- **count update.** `count_next = count + alloc_fire - commit_fire`. Simultaneous allocate and commit leaves `count` unchanged.
- **Lookup (combinational).**
  - If `wb_valid && wb_idx == rd_idx` and the entry is valid: `rd_ready=1`, `rd_data=wb_result_lo` (bypass).
  - Otherwise `rd_ready = valid && done`, `rd_data = result_lo`.
  - When `rd_ready=0`, `rd_data` is don't-care.
- **Flush** has priority over everything:
  - all `valid` and `done` bits clear;
  - `head=tail=0`, `count=0`;
  - commit outputs are 0 next cycle;
  - same-cycle allocate, writeback and commit are discarded.
- **Reset.** Every output and state bit is 0 and the pointers are 0. Consequently `alloc_ready=1` and `empty=1` after reset. Reset asserted mid-operation drops all entries immediately and asynchronously.

## Timing
- **Allocate:** `alloc_idx` is valid combinationally in the request cycle. The entry is occupied from the next edge.
- **Writeback to commit:**
  - Writeback sampled at edge N sets `done`.
  - If that entry is at `head`, commit fires at edge N+1.
  - `rf_we` is high in the cycle after edge N+1, for exactly one cycle per retired entry.
- **Back-to-back commit:** consecutive done entries retire on consecutive edges.
- **Allocate into a freed slot:** an entry freed by a commit at edge N can be reallocated in the cycle after N.
- **Lookup:** zero cycles (combinational), including the same-cycle writeback bypass.
- **Flush latency:** asserted in cycle C, the ROB is empty from edge C.

## Test plan
- Reset, then allocate 3 entries (dest r1, r2, r3) → `alloc_idx` 0, 1, 2; `count=3`; `empty=0`.
- Write back idx 2, then 1, then 0 with lo values 0x30, 0x20, 0x10 → `rf_we` pulses carry r1=0x10, r2=0x20, r3=0x30 in order on consecutive cycles; `rf_we` is first high two edges after idx 0's writeback.
- Allocate 16 entries → `alloc_ready=0`; a 17th request is ignored. Then:
  - write back all 16 → 16 commits;
  - `head` and `tail` wrap to 0;
  - `empty=1`.
- Lookup of an entry with a same-cycle writeback (`rd_idx = wb_idx = 5`, lo 0xDEAD) → `rd_ready=1`, `rd_data=0xDEAD`. The entry for the non-written `rd_idx` 6 → `rd_ready=0`.
- Flush:
  - with 5 entries in flight and a same-cycle alloc, writeback and commit-ready head → next cycle `count=0`, `rf_we=0`, `alloc_idx=0`;
  - a later writeback to an old index is ignored.
- Entry with `dest_reg_valid=0` retires → `commit_valid=1`, `rf_we=0`. `reset_n` pulsed low mid-stream → all outputs 0 immediately.
